// File: rtl/dda_pkg.sv
// Shared types and constants for the DDA grid stepper.
`timescale 1ns/1ps
package dda_pkg;

    typedef enum logic [2:0] {IDLE, STEP, FETCH, CHECK, DONE} state_t;

    typedef logic [15:0] q8_8_t;

    localparam logic [3:0] WALL_OOB = 4'hF;
    localparam int DEFAULT_MAP_SIZE = 24;

endpackage

// File: rtl/dda_map_addr.sv
// Next-cell computation for one DDA step: moves one axis, flags map-edge exits
// and forms the linear map address of the resulting cell.
`timescale 1ns/1ps
module dda_map_addr
    import dda_pkg::*;
#(
    parameter int MAP_SIZE = DEFAULT_MAP_SIZE
) (
    input  logic [4:0] map_x,
    input  logic [4:0] map_y,
    input  logic       step_x,
    input  logic       step_y,
    input  logic       move_y,
    output logic [4:0] next_x,
    output logic [4:0] next_y,
    output logic       oob,
    output logic [9:0] addr
);

    localparam logic [4:0] LAST = 5'(MAP_SIZE - 1);

    // An exit leaves the coordinate untouched so the address stays inside the map
    always_comb begin
        next_x = map_x;
        next_y = map_y;
        oob    = 1'b0;
        if (move_y) begin
            if (step_y ? (map_y == LAST) : (map_y == 5'd0))
                oob = 1'b1;
            else
                next_y = step_y ? map_y + 5'd1 : map_y - 5'd1;
        end else begin
            if (step_x ? (map_x == LAST) : (map_x == 5'd0))
                oob = 1'b1;
            else
                next_x = step_x ? map_x + 5'd1 : map_x - 5'd1;
        end
    end

    assign addr = ({5'd0, next_y} * 10'(MAP_SIZE)) + {5'd0, next_x};

endmodule

// File: rtl/dda_stepper.sv
// DDA grid walker: one ray at a time from setup to wall hit / map exit.
// Optional DDA_TIMEOUT_EN ends a walk after MAX_STEPS steps with no hit.
`timescale 1ns/1ps
module dda_stepper
    import dda_pkg::*;
#(
    parameter int MAP_SIZE    = DEFAULT_MAP_SIZE,
    parameter int MAP_LATENCY = 2,
    parameter int MAX_STEPS   = 64
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        ray_valid_in,
    output logic        ray_ready_out,
    input  logic [8:0]  hcount_in,
    input  logic [4:0]  mapX_in,
    input  logic [4:0]  mapY_in,
    input  logic        stepX_in,
    input  logic        stepY_in,
    input  logic [15:0] sideDistX_in,
    input  logic [15:0] sideDistY_in,
    input  logic [15:0] deltaDistX_in,
    input  logic [15:0] deltaDistY_in,
    output logic [9:0]  map_addr_out,
    input  logic [3:0]  map_data_in,
    output logic        hit_valid_out,
    input  logic        hit_ready_in,
    output logic [8:0]  hit_hcount_out,
    output logic [15:0] perpDist_out,
    output logic        side_out,
    output logic [3:0]  wall_type_out
);

    function automatic q8_8_t sat_add(input q8_8_t a, input q8_8_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic q8_8_t wrap_sub(input q8_8_t a, input q8_8_t b);
        return a - b;
    endfunction

    state_t     state;
    logic [4:0] map_x, map_y;
    logic       step_x, step_y;
    q8_8_t      side_x, side_y, delta_x, delta_y;
    logic       side;
    logic [3:0] wall;
    logic [8:0] hcount;
    logic [7:0] wait_cnt;

    logic       accept, move_y, oob;
    logic [4:0] next_x, next_y;
    logic [9:0] next_addr;
    q8_8_t      sum_x, sum_y, perp;

    assign accept = (state == IDLE) && ray_ready_out && ray_valid_in;
    // Ties go to the Y axis
    assign move_y = !(side_x < side_y);
    assign sum_x  = sat_add(side_x, delta_x);
    assign sum_y  = sat_add(side_y, delta_y);
    assign perp   = side ? wrap_sub(side_y, delta_y) : wrap_sub(side_x, delta_x);

    dda_map_addr #(.MAP_SIZE(MAP_SIZE)) u_map_addr (
        .map_x  (map_x),
        .map_y  (map_y),
        .step_x (step_x),
        .step_y (step_y),
        .move_y (move_y),
        .next_x (next_x),
        .next_y (next_y),
        .oob    (oob),
        .addr   (next_addr)
    );

    // Walk datapath: loaded on accept, advanced per step, never reset
    always_ff @(posedge pixel_clk_in) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    map_x   <= mapX_in;
                    map_y   <= mapY_in;
                    step_x  <= stepX_in;
                    step_y  <= stepY_in;
                    side_x  <= sideDistX_in;
                    side_y  <= sideDistY_in;
                    delta_x <= deltaDistX_in;
                    delta_y <= deltaDistY_in;
                    hcount  <= hcount_in;
                end
            end
            STEP: begin
                if (move_y) side_y <= sum_y;
                else        side_x <= sum_x;
                side  <= move_y;
                map_x <= next_x;
                map_y <= next_y;
                if (oob) wall <= WALL_OOB;
            end
            CHECK: wall <= (map_data_in != 4'd0) ? map_data_in : WALL_OOB;
            default: ;
        endcase
    end

`ifdef DDA_TIMEOUT_EN
    logic [15:0] step_cnt;
`else
    logic unused_max_steps;
    assign unused_max_steps = (MAX_STEPS != 0);
`endif

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            ray_ready_out  <= 1'b0;
            hit_valid_out  <= 1'b0;
            perpDist_out   <= '0;
            side_out       <= 1'b0;
            wall_type_out  <= '0;
            hit_hcount_out <= '0;
            map_addr_out   <= '0;
            wait_cnt       <= '0;
`ifdef DDA_TIMEOUT_EN
            step_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ray_ready_out <= 1'b1;
                    if (accept) begin
                        ray_ready_out <= 1'b0;
                        state         <= STEP;
`ifdef DDA_TIMEOUT_EN
                        step_cnt      <= '0;
`endif
                    end
                end
                STEP: begin
`ifdef DDA_TIMEOUT_EN
                    step_cnt <= step_cnt + 16'd1;
`endif
                    if (oob) begin
                        state <= DONE;
                    end else begin
                        map_addr_out <= next_addr;
                        wait_cnt     <= '0;
                        state        <= (MAP_LATENCY > 1) ? FETCH : CHECK;
                    end
                end
                FETCH: begin
                    if (wait_cnt == 8'(MAP_LATENCY - 2)) state <= CHECK;
                    else wait_cnt <= wait_cnt + 8'd1;
                end
                CHECK: begin
                    if (map_data_in != 4'd0)
                        state <= DONE;
`ifdef DDA_TIMEOUT_EN
                    else if (step_cnt == 16'(MAX_STEPS))
                        state <= DONE;
`endif
                    else
                        state <= STEP;
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds for the handshake
                    if (!hit_valid_out) begin
                        hit_valid_out  <= 1'b1;
                        perpDist_out   <= perp;
                        side_out       <= side;
                        wall_type_out  <= wall;
                        hit_hcount_out <= hcount;
                    end else if (hit_ready_in) begin
                        hit_valid_out <= 1'b0;
                        ray_ready_out <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dda_stepper.sv
// Directed bench for dda_stepper with a registered map model (MAP_LATENCY=2).
`timescale 1ns/1ps
module tb_dda_stepper;

    localparam int MAP_SIZE    = 24;
    localparam int MAP_LATENCY = 2;
    localparam int MAX_STEPS   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ray_valid = 1'b0;
    logic        ray_ready;
    logic [8:0]  hcount = '0;
    logic [4:0]  map_x = '0, map_y = '0;
    logic        step_x = 1'b0, step_y = 1'b0;
    logic [15:0] side_x = '0, side_y = '0, delta_x = '0, delta_y = '0;
    logic [9:0]  map_addr;
    logic [3:0]  map_rd;
    logic        hit_valid;
    logic        hit_ready = 1'b0;
    logic [8:0]  hit_hcount;
    logic [15:0] perp;
    logic        side;
    logic [3:0]  wall_type;

    logic [3:0]  map_mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int cnt;

    always #5 clk = ~clk;

    // One register stage after the DUT's registered address gives two cycles of latency
    always_ff @(posedge clk) map_rd <= map_mem[map_addr];

    dda_stepper #(
        .MAP_SIZE(MAP_SIZE), .MAP_LATENCY(MAP_LATENCY), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .ray_valid_in  (ray_valid),
        .ray_ready_out (ray_ready),
        .hcount_in     (hcount),
        .mapX_in       (map_x),
        .mapY_in       (map_y),
        .stepX_in      (step_x),
        .stepY_in      (step_y),
        .sideDistX_in  (side_x),
        .sideDistY_in  (side_y),
        .deltaDistX_in (delta_x),
        .deltaDistY_in (delta_y),
        .map_addr_out  (map_addr),
        .map_data_in   (map_rd),
        .hit_valid_out (hit_valid),
        .hit_ready_in  (hit_ready),
        .hit_hcount_out(hit_hcount),
        .perpDist_out  (perp),
        .side_out      (side),
        .wall_type_out (wall_type)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < 1024; i++) map_mem[i] = 4'd0;
    endtask

    task automatic set_cell(input int x, input int y, input logic [3:0] v);
        map_mem[y * MAP_SIZE + x] = v;
    endtask

    task automatic start_ray(input logic [8:0] hc, input logic [4:0] mx, input logic [4:0] my,
                             input logic sx, input logic sy, input logic [15:0] sdx,
                             input logic [15:0] sdy, input logic [15:0] dx, input logic [15:0] dy);
        int guard = 0;
        while (!ray_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ray_ready_before_accept", ray_ready, 1);
        hcount = hc; map_x = mx; map_y = my; step_x = sx; step_y = sy;
        side_x = sdx; side_y = sdy; delta_x = dx; delta_y = dy;
        ray_valid = 1'b1;
        @(posedge clk); #1;
        ray_valid = 1'b0;
        check("ray_ready_after_accept", ray_ready, 0);
    endtask

    task automatic wait_hit(output int l);
        l = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            l = c;
            if (hit_valid) break;
        end
        check("hit_valid_seen", hit_valid, 1);
    endtask

    task automatic finish_hit();
        hit_ready = 1'b1;
        @(posedge clk); #1;
        hit_ready = 1'b0;
        check("valid_after_handshake", hit_valid, 0);
        check("ready_after_handshake", ray_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_map();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ray_ready", ray_ready, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_perp", perp, 0);
        check("rst_side", side, 0);
        check("rst_wall", wall_type, 0);
        check("rst_hcount", hit_hcount, 0);
        check("rst_addr", map_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", ray_ready, 1);

        // X-column wall at x=7: hit (7,6) after 3 steps
        for (int y = 0; y < MAP_SIZE; y++) set_cell(7, y, 4'h5);
        start_ray(9'd100, 5'd5, 5'd5, 1'b1, 1'b1, 16'h0080, 16'h0100, 16'h0100, 16'h0200);
        wait_hit(lat);
        check("xcol_latency", lat, 10);
        check("xcol_perp", perp, 16'h0180);
        check("xcol_side", side, 0);
        check("xcol_wall", wall_type, 4'h5);
        check("xcol_hcount", hit_hcount, 9'd100);
        check("xcol_addr", map_addr, 10'd151);

        // Backpressure with a competing ray offered
        hcount = 9'd300; map_x = 5'd1; map_y = 5'd1; side_x = 16'h0001;
        ray_valid = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (hit_valid && perp == 16'h0180 && side == 1'b0 && wall_type == 4'h5 &&
                hit_hcount == 9'd100 && !ray_ready) cnt++;
        end
        check("bp_stable_cycles", cnt, 20);
        ray_valid = 1'b0;
        finish_hit();
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!hit_valid && ray_ready) cnt++;
        end
        check("bp_second_ray_ignored", cnt, 5);

        // Tie on equal side distances steps Y
        clear_map();
        set_cell(10, 11, 4'h3);
        start_ray(9'd200, 5'd10, 5'd10, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0180, 16'h00C0);
        wait_hit(lat);
        check("tie_latency", lat, 4);
        check("tie_side", side, 1);
        check("tie_perp", perp, 16'h0100);
        check("tie_wall", wall_type, 4'h3);
        check("tie_addr", map_addr, 10'd274);
        finish_hit();

        // Left edge exit: no map read, address unchanged
        clear_map();
        start_ray(9'd7, 5'd0, 5'd3, 1'b0, 1'b1, 16'h0010, 16'h0800, 16'h0100, 16'h0100);
        wait_hit(lat);
        check("oob_latency", lat, 2);
        check("oob_wall", wall_type, 4'hF);
        check("oob_side", side, 0);
        check("oob_perp", perp, 16'h0010);
        check("oob_addr_kept", map_addr, 10'd274);
        check("oob_hcount", hit_hcount, 9'd7);
        finish_hit();

        // Bottom edge exit on a Y step
        start_ray(9'd8, 5'd4, 5'd23, 1'b1, 1'b1, 16'h0300, 16'h0040, 16'h0100, 16'h0100);
        wait_hit(lat);
        check("oobY_latency", lat, 2);
        check("oobY_wall", wall_type, 4'hF);
        check("oobY_side", side, 1);
        check("oobY_perp", perp, 16'h0040);
        finish_hit();

        // Saturating side-distance add, -X step
        set_cell(11, 4, 4'h9);
        start_ray(9'd9, 5'd12, 5'd4, 1'b0, 1'b0, 16'hFF80, 16'hFFFF, 16'h0100, 16'h0100);
        wait_hit(lat);
        check("sat_latency", lat, 4);
        check("sat_perp", perp, 16'hFEFF);
        check("sat_side", side, 0);
        check("sat_wall", wall_type, 4'h9);
        check("sat_addr", map_addr, 10'd107);
        finish_hit();

        // Reset during FETCH
        clear_map();
        for (int y = 0; y < MAP_SIZE; y++) set_cell(7, y, 4'h5);
        start_ray(9'd55, 5'd5, 5'd5, 1'b1, 1'b1, 16'h0080, 16'h0100, 16'h0100, 16'h0200);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_ready", ray_ready, 0);
        check("mid_rst_valid", hit_valid, 0);
        check("mid_rst_addr", map_addr, 0);
        check("mid_rst_perp", perp, 0);
        check("mid_rst_wall", wall_type, 0);
        check("mid_rst_hcount", hit_hcount, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (hit_valid) cnt++;
        end
        check("mid_rst_no_hit", cnt, 0);
        check("mid_rst_ready_back", ray_ready, 1);

`ifdef DDA_TIMEOUT_EN
        // Timeout after MAX_STEPS empty steps
        clear_map();
        start_ray(9'd11, 5'd10, 5'd10, 1'b1, 1'b1, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
        wait_hit(lat);
        check("to_latency", lat, 13);
        check("to_wall", wall_type, 4'hF);
        check("to_side", side, 1);
        check("to_perp", perp, 16'h0200);
        finish_hit();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
